// File: rtl/uart_reg_bridge.sv
// -----------------------------------------------------------------------------
// uart_reg_bridge
//
// Byte-level command parser and register bank sitting between the UART RX FIFO
// and the UART TX FIFO. It pops request frames from the RX FIFO, executes them
// against an internal bank of 8-bit registers, and pushes a two-byte response
// frame into the TX FIFO.
//
// Request : A5, CMD, ADDR, [DATA when CMD=01], CSUM  (CSUM = XOR of CMD/ADDR/DATA)
// Response: 5A, RSP  (RSP = 06 write ack, read data, EE bad checksum, EF bad addr)
//
// Parameters
//   NREGS    number of 8-bit registers (2..256), addresses 0..NREGS-1
//   TIMEOUT  inter-byte timeout in clk cycles while inside a frame
//
// Ports
//   clk      system clock (shared with the UART)
//   rstn     asynchronous active-low reset
//   rdata    RX FIFO head byte, valid the cycle after rduart
//   rxempty  RX FIFO empty
//   rduart   RX FIFO pop strobe (single-cycle)
//   wdata    byte to TX FIFO, valid while wruart is high
//   wruart   TX FIFO push strobe (single-cycle)
//   txfull   TX FIFO full
//   regs     flattened register bank, reg i at bits [8i+7:8i]
//   err_cnt  saturating count of rejected frames
// -----------------------------------------------------------------------------
module uart_reg_bridge #(
   parameter int NREGS   = 16,
   parameter int TIMEOUT = 100000
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [7:0]         rdata,
   input  logic               rxempty,
   output logic               rduart,
   output logic [7:0]         wdata,
   output logic               wruart,
   input  logic               txfull,
   output logic [8*NREGS-1:0] regs,
   output logic [7:0]         err_cnt
);

   localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [7:0] HDR_BYTE = 8'hA5;
   localparam logic [7:0] RSP_HDR  = 8'h5A;
   localparam logic [7:0] CMD_WR   = 8'h01;
   localparam logic [7:0] CMD_RD   = 8'h02;
   localparam logic [7:0] RSP_ACK  = 8'h06;
   localparam logic [7:0] RSP_CSUM = 8'hEE;
   localparam logic [7:0] RSP_ADDR = 8'hEF;

   typedef enum logic [2:0] {
      S_HDR, S_CMD, S_ADDR, S_DATA, S_CSUM, S_EXEC, S_RSP0, S_RSP1
   } state_t;

   state_t        r_state;
   logic          r_rduart;    // pop strobe currently on the RX FIFO
   logic          r_valid;     // rdata holds the byte popped last cycle
   logic          r_wruart;
   logic [7:0]    r_wdata;
   logic [7:0]    r_cmd;
   logic [7:0]    r_addr;
   logic [7:0]    r_data;
   logic [7:0]    r_csum;      // running XOR of CMD/ADDR/DATA
   logic          r_csum_ok;
   logic [7:0]    r_rsp;       // response byte latched in EXEC
   logic [7:0]    r_err_cnt;
   logic [TW-1:0] r_tcnt;
   logic [7:0]    r_regs [NREGS];

   logic          w_rx_state;
   logic          w_fetch_idle;
   logic          w_timeout;
   logic          w_addr_ok;
   logic [AW-1:0] w_idx;
   logic [7:0]    w_rd_byte;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign w_rx_state   = (r_state == S_HDR)  || (r_state == S_CMD)  ||
                         (r_state == S_ADDR) || (r_state == S_DATA) ||
                         (r_state == S_CSUM);
   assign w_fetch_idle = !r_rduart && !r_valid;

   // A timeout only fires with no fetch in flight, so a byte already popped
   // is never silently dropped by the timeout path.
   assign w_timeout    = w_rx_state && (r_state != S_HDR) && w_fetch_idle &&
                         (r_tcnt >= TW'(TIMEOUT - 1));

   assign w_addr_ok    = int'(r_addr) < NREGS;
   assign w_idx        = r_addr[AW-1:0];
   assign w_rd_byte    = r_regs[w_idx];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state   <= S_HDR;
         r_rduart  <= 1'b0;
         r_valid   <= 1'b0;
         r_wruart  <= 1'b0;
         r_wdata   <= 8'h00;
         r_cmd     <= 8'h00;
         r_addr    <= 8'h00;
         r_data    <= 8'h00;
         r_csum    <= 8'h00;
         r_csum_ok <= 1'b0;
         r_rsp     <= 8'h00;
         r_err_cnt <= 8'h00;
         r_tcnt    <= '0;
         // NOTE: the bank is plain flops visible on a port, not a RAM macro,
         //       so it is reset with the rest of the state.
         for (int i = 0; i < NREGS; i++) r_regs[i] <= 8'h00;
      end else begin
         // NOTE: every state element uses non-blocking assignments, so all
         //       branches see pre-edge values whatever the statement order;
         //       the defaults below are simply overridden later in the block.
         r_rduart <= 1'b0;
         r_wruart <= 1'b0;
         r_valid  <= r_rduart;

         if (w_rx_state) begin
            if (r_valid) begin
               // Byte capture. Chain the next pop straight away unless this
               // byte completes the frame, giving one byte every two cycles.
               r_tcnt   <= '0;
               r_rduart <= (r_state != S_CSUM) && !rxempty;
               case (r_state)
                  S_HDR: begin
                     if (rdata == HDR_BYTE) r_state <= S_CMD;
                  end
                  S_CMD: begin
                     r_cmd  <= rdata;
                     r_csum <= rdata;
                     if (rdata == CMD_WR || rdata == CMD_RD) begin
                        r_state <= S_ADDR;
                     end else begin
                        r_state   <= S_HDR;
                        r_err_cnt <= sat_inc(r_err_cnt);
                     end
                  end
                  S_ADDR: begin
                     r_addr  <= rdata;
                     r_csum  <= r_csum ^ rdata;
                     r_state <= (r_cmd == CMD_WR) ? S_DATA : S_CSUM;
                  end
                  S_DATA: begin
                     r_data  <= rdata;
                     r_csum  <= r_csum ^ rdata;
                     r_state <= S_CSUM;
                  end
                  default: begin  // S_CSUM
                     r_csum_ok <= (rdata == r_csum);
                     r_state   <= S_EXEC;
                  end
               endcase
            end else if (w_timeout) begin
               r_state   <= S_HDR;
               r_tcnt    <= '0;
               r_err_cnt <= sat_inc(r_err_cnt);
            end else begin
               // r_valid is low here, so idle simply means no pop last cycle.
               r_rduart <= !r_rduart && !rxempty;
               if (r_state == S_HDR) r_tcnt <= '0;
               else                  r_tcnt <= r_tcnt + TW'(1);
            end
         end else begin
            case (r_state)
               S_EXEC: begin
                  if (!r_csum_ok) begin
                     r_rsp     <= RSP_CSUM;
                     r_err_cnt <= sat_inc(r_err_cnt);
                  end else if (!w_addr_ok) begin
                     r_rsp     <= RSP_ADDR;
                     r_err_cnt <= sat_inc(r_err_cnt);
                  end else if (r_cmd == CMD_WR) begin
                     r_regs[w_idx] <= r_data;
                     r_rsp         <= RSP_ACK;
                  end else begin
                     r_rsp <= w_rd_byte;
                  end
                  // Issue the response header from EXEC when the TX FIFO has
                  // room; otherwise park in RSP0 until it does.
                  if (!txfull) begin
                     r_wruart <= 1'b1;
                     r_wdata  <= RSP_HDR;
                     r_state  <= S_RSP1;
                  end else begin
                     r_state  <= S_RSP0;
                  end
               end
               S_RSP0: begin
                  if (!txfull) begin
                     r_wruart <= 1'b1;
                     r_wdata  <= RSP_HDR;
                     r_state  <= S_RSP1;
                  end
               end
               S_RSP1: begin
                  if (!txfull) begin
                     r_wruart <= 1'b1;
                     r_wdata  <= r_rsp;
                     r_state  <= S_HDR;
                  end
               end
               default: r_state <= S_HDR;
            endcase
         end
      end
   end

   for (genvar gi = 0; gi < NREGS; gi++) begin : g_flat
      assign regs[8*gi +: 8] = r_regs[gi];
   end

   assign rduart  = r_rduart;
   assign wruart  = r_wruart;
   assign wdata   = r_wdata;
   assign err_cnt = r_err_cnt;

endmodule
